// File: rtl/aes_key_expand_seq_pkg.sv
// AES-256 key schedule shared definitions: S-box table, xtime, sequencer states.
// Latency: n/a (constants and pure functions only).
// Backpressure: n/a.
package aes_pkg;

    localparam int         AES256_NUM_RK = 15;
    localparam logic [7:0] AES_RCON_INIT = 8'h01;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HI   = 2'd1,
        ST_LO   = 2'd2
    } seq_state_t;

    // Forward AES S-box, entry i is SubBytes(i).
    localparam logic [7:0] AES_SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    // GF(2^8) multiply by x; used to step Rcon between expansion rounds.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Rotate a key word left by one byte.
    function automatic logic [31:0] rot_word(input logic [31:0] w);
        return {w[23:0], w[31:24]};
    endfunction

endpackage

// File: rtl/aes_key_expand_seq_if.sv
// Start/key request and round-key stream bundle for the key expansion sequencer.
// Latency: n/a (wires only).
// Backpressure: outRkValid/inRkReady handshake on the round-key stream.
interface aes_key_expand_seq_if;

    logic         inStart;
    logic [255:0] inKey;
    logic         outBusy;
    logic         outRkValid;
    logic         inRkReady;
    logic [127:0] outRk;
    logic [3:0]   outRkIdx;
    logic         outDone;

    // Requester / round-key consumer side.
    modport master (
        output inStart, inKey, inRkReady,
        input  outBusy, outRkValid, outRk, outRkIdx, outDone
    );

    // Sequencer side.
    modport slave (
        input  inStart, inKey, inRkReady,
        output outBusy, outRkValid, outRk, outRkIdx, outDone
    );

endinterface

// File: rtl/aes_key_expand_seq_sbox.sv
// Single AES S-box byte lookup from the shared table.
// Latency: purely combinational.
// Backpressure: none.
module aes_sbox
    import aes_pkg::*;
(
    input  logic [7:0] din,
    output logic [7:0] dout
);

    assign dout = AES_SBOX[din];

endmodule

// File: rtl/aes_key_expand_seq.sv
// AES-256 key expansion sequencer streaming rk0..rk14 as 128-bit halves of the 256-bit key state.
// Latency: rk0 valid the cycle after start acceptance; one round key per cycle when the consumer is ready.
// Backpressure: round key, index and all state hold while outRkValid is high and inRkReady is low.
module aes_key_expand_seq
    import aes_pkg::*;
(
    input  logic                 inClk,
    input  logic                 inRst,
    aes_key_expand_seq_if.slave  bus
);

    localparam logic [3:0] LAST_IDX = 4'(AES256_NUM_RK - 1);

    seq_state_t   state;
    seq_state_t   state_nxt;
    logic [255:0] reg_state;
    logic [7:0]   reg_rcon;
    logic [3:0]   reg_idx;
    logic         done_q;

    logic         load_key;
    logic         step;
    logic         idx_inc;
    logic         done_nxt;
    logic         rk_valid;
    logic [127:0] rk;
    logic [3:0]   rk_idx;
    logic         busy;

    // Current 8-word window of the schedule, p0 in the MSBs.
    logic [31:0] p0, p1, p2, p3, p4, p5, p6, p7;
    logic [31:0] n0, n1, n2, n3, n4, n5, n6, n7;
    logic [31:0] rot_p7;
    logic [31:0] sub_rot;
    logic [31:0] sub_n3;
    logic [255:0] state_next;

    assign p0 = reg_state[255:224];
    assign p1 = reg_state[223:192];
    assign p2 = reg_state[191:160];
    assign p3 = reg_state[159:128];
    assign p4 = reg_state[127:96];
    assign p5 = reg_state[95:64];
    assign p6 = reg_state[63:32];
    assign p7 = reg_state[31:0];

    assign rot_p7 = rot_word(p7);

    // Two SubWord stages: one on RotWord(p7) for the even half, one on n3 for the odd half.
    for (genvar b = 0; b < 4; b++) begin : g_sbox
        aes_sbox u_sbox_rot (
            .din  (rot_p7[8*b +: 8]),
            .dout (sub_rot[8*b +: 8])
        );
        aes_sbox u_sbox_mid (
            .din  (n3[8*b +: 8]),
            .dout (sub_n3[8*b +: 8])
        );
    end

    assign n0 = p0 ^ sub_rot ^ {reg_rcon, 24'h0};
    assign n1 = p1 ^ n0;
    assign n2 = p2 ^ n1;
    assign n3 = p3 ^ n2;
    assign n4 = p4 ^ sub_n3;
    assign n5 = p5 ^ n4;
    assign n6 = p6 ^ n5;
    assign n7 = p7 ^ n6;

    assign state_next = {n0, n1, n2, n3, n4, n5, n6, n7};

    // FSM state register.
    always_ff @(posedge inClk) begin
        if (inRst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state, stream outputs and datapath strobes.
    always_comb begin
        state_nxt = state;
        load_key  = 1'b0;
        step      = 1'b0;
        idx_inc   = 1'b0;
        done_nxt  = 1'b0;
        rk_valid  = 1'b0;
        rk        = '0;
        rk_idx    = '0;
        busy      = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (bus.inStart) begin
                    load_key  = 1'b1;
                    state_nxt = ST_HI;
                end
            end
            ST_HI: begin
                rk_valid = 1'b1;
                rk       = reg_state[255:128];
                rk_idx   = reg_idx;
                busy     = 1'b1;
                if (bus.inRkReady) begin
                    if (reg_idx == LAST_IDX) begin
                        done_nxt  = 1'b1;
                        state_nxt = ST_IDLE;
                    end else begin
                        idx_inc   = 1'b1;
                        state_nxt = ST_LO;
                    end
                end
            end
            ST_LO: begin
                rk_valid = 1'b1;
                rk       = reg_state[127:0];
                rk_idx   = reg_idx;
                busy     = 1'b1;
                if (bus.inRkReady) begin
                    step      = 1'b1;
                    idx_inc   = 1'b1;
                    state_nxt = ST_HI;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Key-schedule register stage: load on start, advance one 8-word step per LO handshake.
    always_ff @(posedge inClk) begin
        if (inRst) begin
            reg_state <= '0;
            reg_rcon  <= AES_RCON_INIT;
            reg_idx   <= '0;
        end else if (load_key) begin
            reg_state <= bus.inKey;
            reg_rcon  <= AES_RCON_INIT;
            reg_idx   <= '0;
        end else begin
            if (step) begin
                reg_state <= state_next;
                reg_rcon  <= xtime(reg_rcon);
            end
            if (idx_inc) begin
                reg_idx <= reg_idx + 4'd1;
            end
        end
    end

    // Completion pulse, raised for the cycle after the rk14 handshake.
    always_ff @(posedge inClk) begin
        if (inRst) begin
            done_q <= 1'b0;
        end else begin
            done_q <= done_nxt;
        end
    end

    assign bus.outRkValid = rk_valid;
    assign bus.outRk      = rk;
    assign bus.outRkIdx   = rk_idx;
    assign bus.outBusy    = busy;
    assign bus.outDone    = done_q;

endmodule

// File: tb/tb_aes_key_expand_seq.sv
`timescale 1ns/1ps
module tb_aes_key_expand_seq;

    localparam logic [255:0] KEY_A = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
    localparam logic [255:0] KEY_B = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] A_RK0  = 128'h603deb1015ca71be2b73aef0857d7781;
    localparam logic [127:0] A_RK2  = 128'h9ba354118e6925afa51a8b5f2067fcde;
    localparam logic [127:0] A_RK3  = 128'ha8b09c1a93d194cdbe49846eb75d5b9a;
    localparam logic [127:0] A_RK14 = 128'hfe4890d1e6188d0b046df344706c631e;
    localparam logic [127:0] Z_RK2  = 128'h62636363626363636263636362636363;

    logic inClk = 1'b0;
    logic inRst;

    aes_key_expand_seq_if bus();

    aes_key_expand_seq dut (
        .inClk (inClk),
        .inRst (inRst),
        .bus   (bus)
    );

    always #5 inClk = ~inClk;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Independent S-box: multiplicative inverse in GF(2^8) followed by the affine map.
    logic [7:0] sb_ref [256];

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] r;
        logic [7:0] x;
        r = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) r = r ^ x;
            x = x[7] ? ({x[6:0], 1'b0} ^ 8'h1b) : {x[6:0], 1'b0};
        end
        return r;
    endfunction

    task automatic build_sbox();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++) begin
                if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            end
            sb_ref[x] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                      ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
        end
    endtask

    function automatic logic [31:0] subw(input logic [31:0] w);
        return {sb_ref[w[31:24]], sb_ref[w[23:16]], sb_ref[w[15:8]], sb_ref[w[7:0]]};
    endfunction

    typedef struct packed {
        logic [3:0]   idx;
        logic [127:0] rk;
    } exp_t;

    exp_t sb[$];
    logic [127:0] seen_rk [15];

    // Textbook word-by-word AES-256 schedule; pushes rk0..rk14 as expected stream.
    task automatic push_expected(input logic [255:0] key);
        logic [31:0] w [60];
        logic [31:0] t;
        logic [7:0]  rc;
        for (int i = 0; i < 8; i++) w[i] = key[255-32*i -: 32];
        rc = 8'h01;
        for (int i = 8; i < 60; i++) begin
            t = w[i-1];
            if (i % 8 == 0) begin
                t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                rc = gmul(rc, 8'h02);
            end else if (i % 8 == 4) begin
                t = subw(t);
            end
            w[i] = w[i-8] ^ t;
        end
        for (int k = 0; k < 15; k++) begin
            sb.push_back({4'(k), w[4*k], w[4*k+1], w[4*k+2], w[4*k+3]});
        end
    endtask

    // Ready generator: mode 0 always ready, mode 1 random with long stalls on idx 1, 2 and 14.
    int         rdy_mode = 0;
    int         stall = 0;
    logic [3:0] last_idx = 4'hf;
    logic       last_vld = 1'b0;

    always @(posedge inClk) begin
        #1;
        if (rdy_mode == 0) begin
            bus.inRkReady = 1'b1;
        end else begin
            if (bus.outRkValid && (!last_vld || bus.outRkIdx != last_idx) &&
                (bus.outRkIdx == 4'd1 || bus.outRkIdx == 4'd2 || bus.outRkIdx == 4'd14)) begin
                stall = 7;
            end
            if (stall > 0) begin
                bus.inRkReady = 1'b0;
                stall--;
            end else begin
                bus.inRkReady = ($urandom_range(0, 2) != 0);
            end
        end
        last_vld = bus.outRkValid;
        last_idx = bus.outRkIdx;
    end

    // Stream monitor: scoreboard compare on handshakes, hold check on stalls, done pulse check.
    logic [127:0] prev_rk;
    logic [3:0]   prev_idx;
    logic         prev_hold = 1'b0;
    logic         exp_done = 1'b0;

    always @(negedge inClk) begin
        exp_t e;
        if (prev_hold && !inRst) begin
            check("hold_vld", 128'(bus.outRkValid), 128'(1));
            check("hold_rk", bus.outRk, prev_rk);
            check("hold_idx", 128'(bus.outRkIdx), 128'(prev_idx));
        end
        if (exp_done) begin
            check("done_pulse", 128'(bus.outDone), 128'(1));
            check("done_busy", 128'(bus.outBusy), 128'(0));
            exp_done = 1'b0;
        end else begin
            check("done_idle", 128'(bus.outDone), 128'(0));
        end
        if (bus.outRkValid && bus.inRkReady && !inRst) begin
            if (sb.size() == 0) begin
                check("sb_empty", 128'(sb.size()), 128'(1));
            end else begin
                e = sb.pop_front();
                check("rk_idx", 128'(bus.outRkIdx), 128'(e.idx));
                check("rk_dat", bus.outRk, e.rk);
                seen_rk[bus.outRkIdx] = bus.outRk;
                if (bus.outRkIdx == 4'd14) exp_done = 1'b1;
            end
        end
        prev_hold = bus.outRkValid && !bus.inRkReady && !inRst;
        prev_rk   = bus.outRk;
        prev_idx  = bus.outRkIdx;
    end

    task automatic start_run(input logic [255:0] key);
        push_expected(key);
        @(posedge inClk); #1;
        bus.inKey   = key;
        bus.inStart = 1'b1;
        @(posedge inClk); #1;
        bus.inStart = 1'b0;
        bus.inKey   = ~key;
    endtask

    // Counts cycles from the acceptance edge until outDone; cycle 1 is the rk0 cycle.
    task automatic wait_done(input bit chk_lat, output int n);
        n = 0;
        for (int i = 1; i <= 400; i++) begin
            @(negedge inClk);
            if (chk_lat && i == 1) begin
                check("lat_vld", 128'(bus.outRkValid), 128'(1));
                check("lat_idx", 128'(bus.outRkIdx), 128'(0));
                check("lat_busy", 128'(bus.outBusy), 128'(1));
            end
            if (bus.outDone) begin
                n = i;
                break;
            end
        end
        if (n == 0) check("done_timeout", 128'(bus.outDone), 128'(1));
        check("sb_drained", 128'(sb.size()), 128'(0));
    endtask

    task automatic check_a_vectors(input string tag);
        check({tag, "_rk0"}, seen_rk[0], A_RK0);
        check({tag, "_rk2"}, seen_rk[2], A_RK2);
        check({tag, "_rk3"}, seen_rk[3], A_RK3);
        check({tag, "_rk14"}, seen_rk[14], A_RK14);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int d;
        int first;
        int second;
        bit found;

        bus.inStart   = 1'b0;
        bus.inKey     = '0;
        bus.inRkReady = 1'b0;
        inRst         = 1'b1;
        build_sbox();
        for (int k = 0; k < 15; k++) seen_rk[k] = '0;

        // Reset state.
        repeat (2) @(posedge inClk);
        @(negedge inClk);
        check("rst_vld", 128'(bus.outRkValid), 128'(0));
        check("rst_busy", 128'(bus.outBusy), 128'(0));
        check("rst_done", 128'(bus.outDone), 128'(0));
        check("rst_rk", bus.outRk, 128'(0));
        check("rst_idx", 128'(bus.outRkIdx), 128'(0));
        @(posedge inClk); #1;
        inRst = 1'b0;

        // FIPS-197 key, consumer always ready.
        rdy_mode = 0;
        start_run(KEY_A);
        wait_done(1'b1, n);
        check("t1_done_cycle", 128'(n), 128'(16));
        check_a_vectors("t1");

        // Same key under random backpressure.
        rdy_mode = 1;
        start_run(KEY_A);
        wait_done(1'b1, n);
        check_a_vectors("t2");

        // Start with another key while busy must be ignored.
        start_run(KEY_A);
        repeat (4) @(posedge inClk);
        #1;
        bus.inKey   = KEY_B;
        bus.inStart = 1'b1;
        repeat (2) @(posedge inClk);
        #1;
        bus.inStart = 1'b0;
        wait_done(1'b0, n);
        check_a_vectors("t3");
        repeat (2) @(negedge inClk);
        check("t3_no_restart", 128'(bus.outRkValid), 128'(0));
        rdy_mode = 0;

        // Reset while in LO at index 7, then a fresh run.
        start_run(KEY_A);
        found = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge inClk);
            if (bus.outRkValid && bus.outRkIdx == 4'd6) begin
                found = 1'b1;
                break;
            end
        end
        check("t4_reach_idx6", 128'(found), 128'(1));
        @(posedge inClk); #1;
        check("t4_in_idx7", 128'(bus.outRkIdx), 128'(7));
        inRst = 1'b1;
        sb.delete();
        @(posedge inClk); #1;
        inRst = 1'b0;
        @(negedge inClk);
        check("t4_vld", 128'(bus.outRkValid), 128'(0));
        check("t4_busy", 128'(bus.outBusy), 128'(0));
        for (int k = 0; k < 15; k++) seen_rk[k] = '0;
        start_run(KEY_A);
        wait_done(1'b1, n);
        check("t4_done_cycle", 128'(n), 128'(16));
        check_a_vectors("t4");

        // Back-to-back runs with start held high and an all-zero key.
        push_expected('0);
        push_expected('0);
        @(posedge inClk); #1;
        bus.inKey   = '0;
        bus.inStart = 1'b1;
        d = 0;
        first = 0;
        second = 0;
        for (int i = 1; i <= 200; i++) begin
            @(negedge inClk);
            if (bus.outDone) begin
                d++;
                if (d == 1) begin
                    first = i;
                    check("t5_rk2_run1", seen_rk[2], Z_RK2);
                end else begin
                    second = i;
                    bus.inStart = 1'b0;
                    break;
                end
            end
        end
        bus.inStart = 1'b0;
        check("t5_done_count", 128'(d), 128'(2));
        check("t5_first_done", 128'(first), 128'(17));
        check("t5_gap", 128'(second - first), 128'(16));
        check("t5_rk2_run2", seen_rk[2], Z_RK2);
        check("t5_sb_drained", 128'(sb.size()), 128'(0));

        // Reset and start together: stays idle.
        @(posedge inClk); #1;
        inRst       = 1'b1;
        bus.inStart = 1'b1;
        bus.inKey   = KEY_A;
        @(posedge inClk); #1;
        @(negedge inClk);
        check("t6_vld", 128'(bus.outRkValid), 128'(0));
        check("t6_busy", 128'(bus.outBusy), 128'(0));
        check("t6_done", 128'(bus.outDone), 128'(0));
        check("t6_rk", bus.outRk, 128'(0));
        check("t6_idx", 128'(bus.outRkIdx), 128'(0));
        @(posedge inClk); #1;
        inRst       = 1'b0;
        bus.inStart = 1'b0;
        @(negedge inClk);
        check("t6_idle_after", 128'(bus.outRkValid), 128'(0));

        repeat (2) @(posedge inClk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
